// File: rtl/apb_fsm_controller_if.sv
// apb_fsm_controller_if
//   Bundles the AHB-side request signals and the APB-side outputs of the
//   bridge's APB controller.
//   master : upstream / environment view (drives the AHB request, observes APB)
//   slave  : controller view (observes the AHB request, drives APB + Hreadyout)
//   Signals:
//     valid, Haddr, Hwrite, Hwdata        AHB request from the slave interface
//     Pselx, Penable, Pwrite, Paddr, Pwdata  APB bus
//     Hreadyout                           AHB ready back to the master
interface apb_fsm_controller_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic [ADDR_WIDTH-1:0] Haddr;
  logic                  Hwrite;
  logic [DATA_WIDTH-1:0] Hwdata;
  logic [2:0]            Pselx;
  logic                  Penable;
  logic                  Pwrite;
  logic [ADDR_WIDTH-1:0] Paddr;
  logic [DATA_WIDTH-1:0] Pwdata;
  logic                  Hreadyout;

  modport master (
    output valid, Haddr, Hwrite, Hwdata,
    input  Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout
  );

  modport slave (
    input  valid, Haddr, Hwrite, Hwdata,
    output Pselx, Penable, Pwrite, Paddr, Pwdata, Hreadyout
  );
endinterface

// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller
//   APB-side controller of the AHB-to-APB bridge. Each accepted AHB transfer
//   is sequenced into an APB SETUP/ENABLE pair on one of three peripherals;
//   Hreadyout stalls the AHB master while the APB transfer is in flight.
//   Ports:
//     Hclk     bridge clock, rising edge
//     Hresetn  asynchronous active-low reset
//     bus      apb_fsm_controller_if.slave (AHB request in, APB + Hreadyout out)
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no transfer; ready to accept
//   WWAIT    | write accepted, AHB data phase; waiting for Hwdata
//   READ     | APB read SETUP
//   RENABLE  | APB read ENABLE; ready to accept the next transfer
//   WRITE    | APB write SETUP
//   WENABLE  | APB write ENABLE; ready to accept the next transfer
module apb_fsm_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                  Hclk,
  input logic                  Hresetn,
  apb_fsm_controller_if.slave  bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WWAIT   = 3'd1;
  localparam logic [2:0] READ    = 3'd2;
  localparam logic [2:0] RENABLE = 3'd3;
  localparam logic [2:0] WRITE   = 3'd4;
  localparam logic [2:0] WENABLE = 3'd5;

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [2:0]            psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  accept_st;

  // Peripheral map: three consecutive 64 MB windows starting at 0x8000_0000,
  // selected by the top six address bits.
  function automatic logic [2:0] decode(input logic [ADDR_WIDTH-1:0] a);
    logic [5:0] top;
    top = a[ADDR_WIDTH-1 -: 6];
    case (top)
      6'b100000: decode = 3'b001;
      6'b100001: decode = 3'b010;
      6'b100010: decode = 3'b100;
      default:   decode = 3'b000;
    endcase
  endfunction

  assign accept_st = (state == IDLE) || (state == RENABLE) || (state == WENABLE);

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE, RENABLE, WENABLE: begin
        if (bus.valid) state_nxt = bus.Hwrite ? WWAIT : READ;
        else           state_nxt = IDLE;
      end
      WWAIT:   state_nxt = WRITE;
      READ:    state_nxt = RENABLE;
      WRITE:   state_nxt = WENABLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state     <= IDLE;
      pend_addr <= '0;
      psel_q    <= 3'b000;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, RENABLE, WENABLE: begin
          penable_q <= 1'b0;
          if (bus.valid && !bus.Hwrite) begin
            paddr_q  <= bus.Haddr;
            psel_q   <= decode(bus.Haddr);
            pwrite_q <= 1'b0;
          end else if (bus.valid && bus.Hwrite) begin
            // Address phase only; the APB setup waits for the data phase.
            pend_addr <= bus.Haddr;
            psel_q    <= 3'b000;
          end else begin
            psel_q <= 3'b000;
          end
        end
        WWAIT: begin
          // Hwdata is stable here because Hreadyout is low during WWAIT.
          paddr_q   <= pend_addr;
          pwdata_q  <= bus.Hwdata;
          psel_q    <= decode(pend_addr);
          pwrite_q  <= 1'b1;
          penable_q <= 1'b0;
        end
        READ, WRITE: begin
          penable_q <= 1'b1;
        end
        default: begin
          psel_q    <= 3'b000;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  // Decoded from the state register only so there is no input-to-Hreadyout
  // path (Hreadyout feeds back into Hreadyin at system level).
  assign bus.Hreadyout = !((state == WWAIT) || (state == READ) || (state == WRITE));

  assign bus.Pselx   = psel_q;
  assign bus.Penable = penable_q;
  assign bus.Pwrite  = pwrite_q;
  assign bus.Paddr   = paddr_q;
  assign bus.Pwdata  = pwdata_q;

  // accept_st is only a readability alias for the shared accept rule.
  logic unused_ok;
  assign unused_ok = accept_st;

endmodule
